// File: rtl/bitonic_merge_pipe_pkg.sv
// bitonic_merge_pipe_pkg: shared limits and index helpers for the bitonic merge pipeline
package bitonic_merge_pipe_pkg;

   localparam int LOG_MIN = 1;
   localparam int LOG_MAX = 6;

   function automatic bit log_ok(input int lg);
      return (lg >= LOG_MIN) && (lg <= LOG_MAX);
   endfunction

   // lower entry of compare pair p when partners sit 2**b apart (bit b of the index is clear)
   function automatic int pair_lo(input int p, input int b);
      return ((p >> b) << (b + 1)) | (p & ((1 << b) - 1));
   endfunction

endpackage

// File: rtl/bitonic_cas_cell.sv
// bitonic_cas_cell: combinational compare-exchange of one key/label pair, ties never swap
module bitonic_cas_cell #(
   parameter int DATA_WIDTH  = 8,
   parameter int LABEL_WIDTH = 4,
   parameter int SIGNED      = 0
) (
   input  logic                   asc_i,
   input  logic [DATA_WIDTH-1:0]  a_key_i,
   input  logic [DATA_WIDTH-1:0]  b_key_i,
   input  logic [LABEL_WIDTH-1:0] a_lab_i,
   input  logic [LABEL_WIDTH-1:0] b_lab_i,
   output logic [DATA_WIDTH-1:0]  a_key_o,
   output logic [DATA_WIDTH-1:0]  b_key_o,
   output logic [LABEL_WIDTH-1:0] a_lab_o,
   output logic [LABEL_WIDTH-1:0] b_lab_o
);

   logic gt, lt, swap;

   // strict compares only, so equal keys keep their labels in place
   always_comb begin
      gt      = (SIGNED != 0) ? ($signed(a_key_i) > $signed(b_key_i)) : (a_key_i > b_key_i);
      lt      = (SIGNED != 0) ? ($signed(a_key_i) < $signed(b_key_i)) : (a_key_i < b_key_i);
      swap    = asc_i ? gt : lt;
      a_key_o = swap ? b_key_i : a_key_i;
      b_key_o = swap ? a_key_i : b_key_i;
      a_lab_o = swap ? b_lab_i : a_lab_i;
      b_lab_o = swap ? a_lab_i : b_lab_i;
   end

endmodule

// File: rtl/bitonic_merge_pipe.sv
// bitonic_merge_pipe: flow-controlled L-stage bitonic merge network with per-vector direction
module bitonic_merge_pipe
   import bitonic_merge_pipe_pkg::*;
#(
   parameter int LOG_INPUT_NUM = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int LABEL_WIDTH   = 4,
   parameter int SIGNED        = 0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      x_valid,
   output logic                                      x_ready,
   input  logic                                      x_asc,
   input  logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0]  x,
   input  logic [LABEL_WIDTH*(1<<LOG_INPUT_NUM)-1:0] x_label,
   output logic                                      y_valid,
   input  logic                                      y_ready,
   output logic                                      y_asc,
   output logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0]  y,
   output logic [LABEL_WIDTH*(1<<LOG_INPUT_NUM)-1:0] y_label,
   output logic                                      busy
);

   localparam int L  = LOG_INPUT_NUM;
   localparam int N  = 1 << L;
   localparam int KW = DATA_WIDTH * N;
   localparam int LW = LABEL_WIDTH * N;

   if (!log_ok(LOG_INPUT_NUM)) begin : g_bad_log
      $error("bitonic_merge_pipe: LOG_INPUT_NUM out of range 1..6");
   end

   logic [L-1:0]         v_q, asc_q, in_v, in_asc;
   logic [L-1:0][KW-1:0] key_q, key_d, in_key;
   logic [L-1:0][LW-1:0] lab_q, lab_d, in_lab;
   logic [L:0]           en;

   // stage k is fed by the input port (k=0) or by the register of stage k-1
   always_comb begin
      in_v[0]   = x_valid;
      in_asc[0] = x_asc;
      in_key[0] = x;
      in_lab[0] = x_label;
      for (int s = 1; s < L; s++) begin
         in_v[s]   = v_q[s-1];
         in_asc[s] = asc_q[s-1];
         in_key[s] = key_q[s-1];
         in_lab[s] = lab_q[s-1];
      end
   end

   // a stage may load when it is empty or everything downstream of it will advance;
   // unrolled as a reduction so the chain has no self-referencing vector
   assign en[L] = y_ready;
   for (genvar s = 0; s < L; s++) begin : g_en
      assign en[s] = y_ready | ~(&v_q[L-1:s]);
   end

   for (genvar s = 0; s < L; s++) begin : g_stage
      for (genvar p = 0; p < N / 2; p++) begin : g_pair
         localparam int B = L - 1 - s;
         localparam int J = pair_lo(p, B);
         localparam int K = J + (1 << B);
         bitonic_cas_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .LABEL_WIDTH(LABEL_WIDTH),
            .SIGNED     (SIGNED)
         ) u_cas (
            .asc_i  (in_asc[s]),
            .a_key_i(in_key[s][DATA_WIDTH*J +: DATA_WIDTH]),
            .b_key_i(in_key[s][DATA_WIDTH*K +: DATA_WIDTH]),
            .a_lab_i(in_lab[s][LABEL_WIDTH*J +: LABEL_WIDTH]),
            .b_lab_i(in_lab[s][LABEL_WIDTH*K +: LABEL_WIDTH]),
            .a_key_o(key_d[s][DATA_WIDTH*J +: DATA_WIDTH]),
            .b_key_o(key_d[s][DATA_WIDTH*K +: DATA_WIDTH]),
            .a_lab_o(lab_d[s][LABEL_WIDTH*J +: LABEL_WIDTH]),
            .b_lab_o(lab_d[s][LABEL_WIDTH*K +: LABEL_WIDTH])
         );
      end
   end

   // stage registers: hold when disabled, which also freezes the presented output under stall
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         v_q   <= '0;
         asc_q <= '0;
         key_q <= '0;
         lab_q <= '0;
      end else begin
         for (int s = 0; s < L; s++)
            if (en[s]) begin
               v_q[s]   <= in_v[s];
               asc_q[s] <= in_asc[s];
               key_q[s] <= key_d[s];
               lab_q[s] <= lab_d[s];
            end
      end

   assign x_ready = en[0];
   assign y_valid = v_q[L-1];
   assign y_asc   = asc_q[L-1];
   assign y       = key_q[L-1];
   assign y_label = lab_q[L-1];
   assign busy    = |v_q;

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// tb_bitonic_merge_pipe: directed and randomized scoreboard bench for the bitonic merge pipeline
module tb_bitonic_merge_pipe;

   localparam int LG  = 2;
   localparam int N   = 1 << LG;
   localparam int DW  = 8;
   localparam int LW  = 4;
   localparam int KW  = DW * N;
   localparam int LBW = LW * N;

   logic           clk = 1'b0, rst = 1'b0;
   logic           x_valid = 1'b0, x_asc = 1'b0, y_ready = 1'b1;
   logic [KW-1:0]  x = '0;
   logic [LBW-1:0] x_label = '0;
   logic           x_ready0, y_valid0, y_asc0, busy0;
   logic           x_ready1, y_valid1, y_asc1, busy1;
   logic [KW-1:0]  y0, y1;
   logic [LBW-1:0] yl0, yl1;

   int n_chk = 0, n_err = 0;
   bit cur_bitonic = 1'b0;

   logic [KW-1:0]  q_k0[$], q_k1[$];
   logic [LBW-1:0] q_l0[$], q_l1[$];
   logic           q_a0[$], q_a1[$];
   bit             q_b[$];

   bitonic_merge_pipe #(.LOG_INPUT_NUM(LG), .DATA_WIDTH(DW), .LABEL_WIDTH(LW), .SIGNED(0)) u_dut0 (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready0), .x_asc(x_asc), .x(x),
      .x_label(x_label), .y_valid(y_valid0), .y_ready(y_ready), .y_asc(y_asc0), .y(y0),
      .y_label(yl0), .busy(busy0));

   bitonic_merge_pipe #(.LOG_INPUT_NUM(LG), .DATA_WIDTH(DW), .LABEL_WIDTH(LW), .SIGNED(1)) u_dut1 (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready1), .x_asc(x_asc), .x(x),
      .x_label(x_label), .y_valid(y_valid1), .y_ready(y_ready), .y_asc(y_asc1), .y(y1),
      .y_label(yl1), .busy(busy1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: apply the stage-by-stage compare-exchange rule on integer arrays
   function automatic void model(input logic [KW-1:0] k, input logic [LBW-1:0] l, input logic asc,
                                 input bit sg, output logic [KW-1:0] yk, output logic [LBW-1:0] yl);
      int kv[N];
      int lv[N];
      int t, d;
      for (int i = 0; i < N; i++) begin
         kv[i] = sg ? int'($signed(k[DW*i +: DW])) : int'(k[DW*i +: DW]);
         lv[i] = int'(l[LW*i +: LW]);
      end
      for (int st = 0; st < LG; st++) begin
         d = N >> (st + 1);
         for (int j = 0; j < N; j++)
            if ((j & d) == 0 && (asc ? kv[j] > kv[j+d] : kv[j] < kv[j+d])) begin
               t = kv[j]; kv[j] = kv[j+d]; kv[j+d] = t;
               t = lv[j]; lv[j] = lv[j+d]; lv[j+d] = t;
            end
      end
      for (int i = 0; i < N; i++) begin
         yk[DW*i +: DW] = kv[i][DW-1:0];
         yl[LW*i +: LW] = lv[i][LW-1:0];
      end
   endfunction

   function automatic bit sorted_ok(input logic [KW-1:0] k, input logic asc);
      logic [DW-1:0] a, b;
      for (int i = 0; i < N - 1; i++) begin
         a = k[DW*i +: DW];
         b = k[DW*(i+1) +: DW];
         if (asc ? a > b : a < b) return 1'b0;
      end
      return 1'b1;
   endfunction

   // up-then-down vector from random keys; narrow range sometimes to force ties
   task automatic gen_bitonic();
      logic [DW-1:0] v[N];
      logic [DW-1:0] t;
      bit narrow;
      narrow = $urandom_range(0, 3) == 0;
      for (int i = 0; i < N; i++) v[i] = narrow ? DW'($urandom_range(0, 3)) : DW'($urandom);
      if (v[0] > v[1]) begin t = v[0]; v[0] = v[1]; v[1] = t; end
      if (v[2] < v[3]) begin t = v[2]; v[2] = v[3]; v[3] = t; end
      for (int i = 0; i < N; i++) x[DW*i +: DW] = v[i];
      x_label = LBW'($urandom);
      x_asc = 1'($urandom);
      cur_bitonic = 1'b1;
   endtask

   logic [KW-1:0]  py;
   logic [LBW-1:0] pl;
   logic           pa;
   bit             pstall = 1'b0;

   // scoreboard: record accepted vectors, compare presented ones, and check hold under stall
   always @(negedge clk) begin
      logic [KW-1:0]  ek;
      logic [LBW-1:0] el;
      if (!rst) begin
         q_k0.delete(); q_k1.delete(); q_l0.delete(); q_l1.delete();
         q_a0.delete(); q_a1.delete(); q_b.delete();
         pstall = 1'b0;
      end else begin
         if (pstall) begin
            chk("hold_y", y0, py);
            chk("hold_label", yl0, pl);
            chk("hold_asc", y_asc0, pa);
         end
         if (y_valid0 && y_ready) begin
            chk("y0_expected_avail", q_k0.size() > 0, 1);
            if (q_k0.size() > 0) begin
               chk("y0_key", y0, q_k0.pop_front());
               chk("y0_label", yl0, q_l0.pop_front());
               chk("y0_asc", y_asc0, q_a0.pop_front());
               if (q_b.pop_front()) chk("y0_sorted", sorted_ok(y0, y_asc0), 1);
            end
         end
         if (y_valid1 && y_ready) begin
            chk("y1_expected_avail", q_k1.size() > 0, 1);
            if (q_k1.size() > 0) begin
               chk("y1_key", y1, q_k1.pop_front());
               chk("y1_label", yl1, q_l1.pop_front());
               chk("y1_asc", y_asc1, q_a1.pop_front());
            end
         end
         if (x_valid && x_ready0) begin
            model(x, x_label, x_asc, 1'b0, ek, el);
            q_k0.push_back(ek); q_l0.push_back(el); q_a0.push_back(x_asc); q_b.push_back(cur_bitonic);
         end
         if (x_valid && x_ready1) begin
            model(x, x_label, x_asc, 1'b1, ek, el);
            q_k1.push_back(ek); q_l1.push_back(el); q_a1.push_back(x_asc);
         end
         pstall = y_valid0 && !y_ready;
         py = y0; pl = yl0; pa = y_asc0;
      end
   end

   // one vector into an idle pipe; returns just after the edge where it reaches the output
   task automatic send_one(input logic [KW-1:0] k, input logic [LBW-1:0] l, input logic a);
      @(posedge clk); #1;
      x_valid = 1'b1; x = k; x_label = l; x_asc = a; cur_bitonic = 1'b0;
      @(posedge clk); #1;
      x_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, w;
      bit take;
      logic [KW-1:0]  vk[4];
      logic [LBW-1:0] vl[4];
      logic           va[4];

      repeat (2) @(negedge clk);
      chk("rst_y_valid", y_valid0, 0);
      chk("rst_y", y0, 0);
      chk("rst_y_label", yl0, 0);
      chk("rst_y_asc", y_asc0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_x_ready", x_ready0, 1);
      #2 rst = 1'b1;

      // ascending then descending merge back to back
      @(posedge clk); #1;
      x_valid = 1'b1; x_asc = 1'b1; x = 32'h03070501; x_label = 16'h3210; cur_bitonic = 1'b1;
      @(negedge clk);
      chk("t1_x_ready", x_ready0, 1);
      chk("t1_no_early_y", y_valid0, 0);
      @(posedge clk); #1;
      x_asc = 1'b0; x = 32'h03010507;
      @(negedge clk);
      chk("t1_lat1_no_y", y_valid0, 0);
      @(posedge clk); #1;
      x_valid = 1'b0;
      @(negedge clk);
      chk("t1_y_valid", y_valid0, 1);
      chk("t1_keys", y0, 32'h07050301);
      chk("t1_labels", yl0, 16'h2130);
      chk("t1_asc", y_asc0, 1);
      @(negedge clk);
      chk("t2_y_valid_consec", y_valid0, 1);
      chk("t2_keys", y0, 32'h01030507);
      chk("t2_labels", yl0, 16'h2310);
      chk("t2_asc", y_asc0, 0);
      @(negedge clk);
      chk("t2_idle_y_valid", y_valid0, 0);
      chk("t2_idle_busy", busy0, 0);

      // signed versus unsigned comparison
      send_one(32'h800502FF, 16'h3210, 1'b1);
      chk("t3_unsigned", y0, 32'hFF800502);
      chk("t3_signed", y1, 32'h0502FF80);

      // all-equal keys keep labels in place
      send_one(32'h04040404, 16'h3210, 1'b1);
      chk("t4_tie_keys", y0, 32'h04040404);
      chk("t4_tie_labels", yl0, 16'h3210);
      send_one(32'h04040404, 16'h3210, 1'b0);
      chk("t4_tie_labels_desc", yl0, 16'h3210);

      // backpressure: pipe fills to two, stalls, then drains in order
      for (int i = 0; i < 4; i++) begin
         gen_bitonic();
         vk[i] = x; vl[i] = x_label; va[i] = x_asc;
      end
      @(posedge clk); #1;
      y_ready = 1'b0; acc = 0;
      x_valid = 1'b1; x = vk[0]; x_label = vl[0]; x_asc = va[0];
      for (int c = 0; c < 26 && acc < 4; c++) begin
         if (c == 6) begin
            chk("bp_accepted", acc, 2);
            chk("bp_x_ready_low", x_ready0, 0);
            chk("bp_busy", busy0, 1);
            y_ready = 1'b1;
         end
         @(negedge clk);
         take = x_valid && x_ready0;
         @(posedge clk); #1;
         if (take) begin
            acc++;
            if (acc < 4) begin
               x = vk[acc]; x_label = vl[acc]; x_asc = va[acc];
            end else x_valid = 1'b0;
         end
      end
      chk("bp_all_accepted", acc, 4);
      w = 0;
      while (busy0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      #1;
      chk("bp_drained", busy0, 0);
      chk("bp_queue_empty", q_k0.size(), 0);

      // reset with two vectors in flight
      @(posedge clk); #1;
      y_ready = 1'b0;
      gen_bitonic(); x_valid = 1'b1;
      @(posedge clk); #1;
      gen_bitonic();
      @(posedge clk); #1;
      x_valid = 1'b0;
      chk("rs_in_flight", busy0, 1);
      #2 rst = 1'b0;
      #1;
      chk("rs_y_valid", y_valid0, 0);
      chk("rs_busy", busy0, 0);
      chk("rs_y", y0, 0);
      chk("rs_y_label", yl0, 0);
      chk("rs_y_asc", y_asc0, 0);
      @(negedge clk); #2;
      rst = 1'b1;
      y_ready = 1'b1;
      chk("rs_x_ready", x_ready0, 1);
      @(posedge clk); #1;
      gen_bitonic(); x_valid = 1'b1;
      @(negedge clk);
      chk("rs_lat0", y_valid0, 0);
      @(posedge clk); #1;
      x_valid = 1'b0;
      @(negedge clk);
      chk("rs_lat1", y_valid0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rs_lat2", y_valid0, 1);

      // randomized stream with random stalls on both sides
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         take = x_valid && x_ready0;
         @(posedge clk); #1;
         if (take || !x_valid) begin
            gen_bitonic();
            x_valid = $urandom_range(0, 9) < 7;
         end
         y_ready = $urandom_range(0, 9) < 7;
      end
      @(posedge clk); #1;
      x_valid = 1'b0;
      y_ready = 1'b1;
      w = 0;
      while (busy0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      #1;
      chk("rnd_drained", busy0, 0);
      chk("rnd_queue0_empty", q_k0.size(), 0);
      chk("rnd_queue1_empty", q_k1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
